// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} fetch_state_t;

  localparam int PC_W       = 10;
  localparam int INSTR_W    = 9;
  localparam int IMEM_DEPTH = 1024;
  localparam int CNT_W      = 16;
  localparam int BR_OFS_MSB = 7;
endpackage

// File: rtl/next_pc_calc.sv
// Next-PC arithmetic: sequential or relative-branch target, with legal-range check.
module next_pc_calc #(
  parameter int PC_W       = fetch_pkg::PC_W,
  parameter int IMEM_DEPTH = fetch_pkg::IMEM_DEPTH,
  parameter int OFS_W      = fetch_pkg::BR_OFS_MSB + 1
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFS_W-1:0] offset,
  input  logic             take_branch,
  output logic [PC_W-1:0]  next_pc,
  output logic             out_of_range
);
  // Two extra bits: one for sign, one so PC + offset cannot overflow silently.
  localparam int SUM_W = PC_W + 2;
  localparam logic signed [SUM_W-1:0] DEPTH_S = SUM_W'(IMEM_DEPTH);
  localparam logic signed [SUM_W-1:0] ONE_S   = SUM_W'(1);

  logic signed [SUM_W-1:0] pc_s;
  logic signed [SUM_W-1:0] step_s;
  logic signed [SUM_W-1:0] sum_s;

  always_comb begin
    pc_s   = signed'({2'b00, pc});
    step_s = take_branch ? signed'({{(SUM_W-OFS_W){offset[OFS_W-1]}}, offset}) : ONE_S;
    sum_s  = pc_s + step_s;
    next_pc      = sum_s[PC_W-1:0];
    out_of_range = sum_s[SUM_W-1] || (sum_s >= DEPTH_S);
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, feeds the decoder, and sequences IDLE/RUN/HALT/FAULT.
//
//   state | meaning
//   IDLE  | waiting for START after reset
//   RUN   | one instruction fetched per cycle
//   HALT  | program finished, DONE held, START restarts
//   FAULT | PC left the legal range, only RESET exits
module fetch_unit #(
  parameter int PC_W       = fetch_pkg::PC_W,
  parameter int IMEM_DEPTH = fetch_pkg::IMEM_DEPTH,
  parameter int INSTR_W    = fetch_pkg::INSTR_W,
  parameter int CNT_W      = fetch_pkg::CNT_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [PC_W-1:0]    START_ADDR,
  input  logic               BRANCH_EN,
  input  logic               BRANCH_TAKEN,
  input  logic               HALT_REQ,
  input  logic [INSTR_W-1:0] INSTR_DATA,
  output logic [PC_W-1:0]    INSTR_ADDR,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               INSTR_VALID,
  output logic               DONE,
  output logic               FAULT,
  output logic [CNT_W-1:0]   CYCLE_COUNT
);
  import fetch_pkg::*;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_sat;
  logic [PC_W-1:0]  next_pc;
  logic             out_of_range;

  assign INSTR_ADDR  = pc_q;
  assign INSTR_VALID = (state_q == RUN);
  assign INSTRUCTION = INSTR_VALID ? INSTR_DATA : '0;
  assign DONE        = done_q;
  assign FAULT       = fault_q;
  assign CYCLE_COUNT = cnt_q;

  assign cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  next_pc_calc #(
    .PC_W       (PC_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .OFS_W      (BR_OFS_MSB + 1)
  ) u_next_pc (
    .pc           (pc_q),
    .offset       (INSTRUCTION[BR_OFS_MSB:0]),
    .take_branch  (BRANCH_EN && BRANCH_TAKEN),
    .next_pc      (next_pc),
    .out_of_range (out_of_range)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          pc_d    = START_ADDR;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_sat;
        // HALT_REQ is checked first: BRANCH_EN may be X on a done instruction.
        if (HALT_REQ) begin
          done_d  = 1'b1;
          state_d = HALT;
        end else if (out_of_range) begin
          fault_d = 1'b1;
          state_d = fetch_pkg::FAULT;
        end else begin
          pc_d = next_pc;
        end
      end
      HALT: begin
        if (START) begin
          done_d  = 1'b0;
          pc_d    = START_ADDR;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      fetch_pkg::FAULT: fault_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a ROM and decoder-flag model around the DUT.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [9:0]  START_ADDR;
  logic        BRANCH_EN;
  logic        BRANCH_TAKEN;
  logic        HALT_REQ;
  logic [8:0]  INSTR_DATA;
  logic [9:0]  INSTR_ADDR;
  logic [8:0]  INSTRUCTION;
  logic        INSTR_VALID;
  logic        DONE;
  logic        FAULT;
  logic [15:0] CYCLE_COUNT;

  logic [8:0] rom      [0:1023];
  logic       br_map   [0:1023];
  logic       done_map [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  // Stand-in for the ROM and ctrl_decoder: flags derive from the word at the PC.
  assign INSTR_DATA = rom[INSTR_ADDR];
  assign BRANCH_EN  = INSTR_VALID && br_map[INSTR_ADDR];
  assign HALT_REQ   = INSTR_VALID && done_map[INSTR_ADDR];

  fetch_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .START_ADDR   (START_ADDR),
    .BRANCH_EN    (BRANCH_EN),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .HALT_REQ     (HALT_REQ),
    .INSTR_DATA   (INSTR_DATA),
    .INSTR_ADDR   (INSTR_ADDR),
    .INSTRUCTION  (INSTRUCTION),
    .INSTR_VALID  (INSTR_VALID),
    .DONE         (DONE),
    .FAULT        (FAULT),
    .CYCLE_COUNT  (CYCLE_COUNT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_program();
    for (int a = 0; a < 1024; a++) begin
      rom[a] = 9'h000;
      br_map[a] = 1'b0;
      done_map[a] = 1'b0;
    end
  endtask

  task automatic start_at(input logic [9:0] addr);
    START = 1'b1;
    START_ADDR = addr;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tests_run++;
    if (INSTR_ADDR !== 10'd0) begin tests_failed++; $display("FAIL reset_pc got %0d want 0", INSTR_ADDR); end
    tests_run++;
    if ({DONE, FAULT, INSTR_VALID} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {DONE, FAULT, INSTR_VALID}); end
    tests_run++;
    if (CYCLE_COUNT !== 16'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", CYCLE_COUNT); end
    tests_run++;
    if (INSTRUCTION !== 9'd0) begin tests_failed++; $display("FAIL reset_instr got %h want 000", INSTRUCTION); end
  endtask

  task automatic test_straight_line();
    clear_program();
    rom[0] = 9'h041; rom[1] = 9'h042; rom[2] = 9'h043; rom[3] = 9'h044; rom[4] = 9'h045;
    done_map[4] = 1'b1;
    start_at(10'd0);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (INSTR_ADDR !== 10'(i)) begin tests_failed++; $display("FAIL straight_pc step %0d got %0d want %0d", i, INSTR_ADDR, i); end
      tests_run++;
      if (INSTR_VALID !== 1'b1 || DONE !== 1'b0) begin tests_failed++; $display("FAIL straight_valid step %0d got valid=%b done=%b want 1/0", i, INSTR_VALID, DONE); end
      tests_run++;
      if (INSTRUCTION !== 9'(9'h041 + i)) begin tests_failed++; $display("FAIL straight_instr step %0d got %h want %h", i, INSTRUCTION, 9'(9'h041 + i)); end
      tick();
    end
    tests_run++;
    if (DONE !== 1'b1 || INSTR_VALID !== 1'b0) begin tests_failed++; $display("FAIL straight_done got done=%b valid=%b want 1/0", DONE, INSTR_VALID); end
    tests_run++;
    if (CYCLE_COUNT !== 16'd5) begin tests_failed++; $display("FAIL straight_count got %0d want 5", CYCLE_COUNT); end
    tests_run++;
    if (INSTR_ADDR !== 10'd4 || INSTRUCTION !== 9'd0) begin tests_failed++; $display("FAIL straight_hold got pc=%0d instr=%h want 4/000", INSTR_ADDR, INSTRUCTION); end
    tick();
    tests_run++;
    if (DONE !== 1'b1 || CYCLE_COUNT !== 16'd5) begin tests_failed++; $display("FAIL straight_frozen got done=%b count=%0d want 1/5", DONE, CYCLE_COUNT); end
  endtask

  task automatic test_restart();
    done_map[100] = 1'b1;
    start_at(10'd100);
    tests_run++;
    if (DONE !== 1'b0 || INSTR_ADDR !== 10'd100 || CYCLE_COUNT !== 16'd0) begin
      tests_failed++; $display("FAIL restart got done=%b pc=%0d count=%0d want 0/100/0", DONE, INSTR_ADDR, CYCLE_COUNT);
    end
    tick();
    tests_run++;
    if (DONE !== 1'b1 || CYCLE_COUNT !== 16'd1) begin tests_failed++; $display("FAIL restart_halt got done=%b count=%0d want 1/1", DONE, CYCLE_COUNT); end
  endtask

  task automatic test_backward_branch();
    int exp_pc [8] = '{10, 8, 9, 10, 8, 9, 10, 11};
    logic taken [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    clear_program();
    rom[10] = {1'b1, 8'hFE};
    br_map[10] = 1'b1;
    done_map[11] = 1'b1;
    start_at(10'd10);
    for (int i = 0; i < 8; i++) begin
      BRANCH_TAKEN = taken[i];
      tests_run++;
      if (INSTR_ADDR !== 10'(exp_pc[i])) begin tests_failed++; $display("FAIL branch_pc step %0d got %0d want %0d", i, INSTR_ADDR, exp_pc[i]); end
      tick();
    end
    BRANCH_TAKEN = 1'b0;
    tests_run++;
    if (DONE !== 1'b1 || CYCLE_COUNT !== 16'd8) begin tests_failed++; $display("FAIL branch_done got done=%b count=%0d want 1/8", DONE, CYCLE_COUNT); end
  endtask

  task automatic test_not_taken();
    clear_program();
    rom[20] = {1'b1, 8'h05};
    br_map[20] = 1'b1;
    rom[21] = 9'h033;
    done_map[22] = 1'b1;
    start_at(10'd20);
    BRANCH_TAKEN = 1'b0;
    tick();
    tests_run++;
    if (INSTR_ADDR !== 10'd21) begin tests_failed++; $display("FAIL not_taken_pc got %0d want 21", INSTR_ADDR); end
    // Flag high on a branch-free word, with a stray START that RUN must ignore.
    BRANCH_TAKEN = 1'b1;
    START = 1'b1;
    START_ADDR = 10'd500;
    tick();
    START = 1'b0;
    BRANCH_TAKEN = 1'b0;
    tests_run++;
    if (INSTR_ADDR !== 10'd22 || INSTR_VALID !== 1'b1) begin tests_failed++; $display("FAIL no_branch_pc got pc=%0d valid=%b want 22/1", INSTR_ADDR, INSTR_VALID); end
    tick();
    tests_run++;
    if (DONE !== 1'b1 || CYCLE_COUNT !== 16'd3) begin tests_failed++; $display("FAIL not_taken_done got done=%b count=%0d want 1/3", DONE, CYCLE_COUNT); end
  endtask

  task automatic test_spin();
    clear_program();
    rom[30] = {1'b1, 8'h00};
    br_map[30] = 1'b1;
    done_map[31] = 1'b1;
    start_at(10'd30);
    BRANCH_TAKEN = 1'b1;
    tick();
    tick();
    tests_run++;
    if (INSTR_ADDR !== 10'd30 || INSTR_VALID !== 1'b1) begin tests_failed++; $display("FAIL spin_pc got pc=%0d valid=%b want 30/1", INSTR_ADDR, INSTR_VALID); end
    BRANCH_TAKEN = 1'b0;
    tick();
    tests_run++;
    if (INSTR_ADDR !== 10'd31) begin tests_failed++; $display("FAIL spin_exit got %0d want 31", INSTR_ADDR); end
    tick();
    tests_run++;
    if (DONE !== 1'b1 || CYCLE_COUNT !== 16'd4) begin tests_failed++; $display("FAIL spin_done got done=%b count=%0d want 1/4", DONE, CYCLE_COUNT); end
  endtask

  task automatic test_range_fault();
    clear_program();
    rom[1] = {1'b1, 8'hFC};
    br_map[1] = 1'b1;
    start_at(10'd1);
    BRANCH_TAKEN = 1'b1;
    tick();
    BRANCH_TAKEN = 1'b0;
    tests_run++;
    if (FAULT !== 1'b1 || INSTR_ADDR !== 10'd1 || INSTR_VALID !== 1'b0 || DONE !== 1'b0) begin
      tests_failed++; $display("FAIL fault_low got fault=%b pc=%0d valid=%b done=%b want 1/1/0/0", FAULT, INSTR_ADDR, INSTR_VALID, DONE);
    end
    tests_run++;
    if (CYCLE_COUNT !== 16'd1) begin tests_failed++; $display("FAIL fault_count got %0d want 1", CYCLE_COUNT); end
    start_at(10'd50);
    tick();
    tests_run++;
    if (FAULT !== 1'b1 || INSTR_ADDR !== 10'd1 || INSTR_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL fault_start_ignored got fault=%b pc=%0d valid=%b want 1/1/0", FAULT, INSTR_ADDR, INSTR_VALID);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tests_run++;
    if (FAULT !== 1'b0 || INSTR_ADDR !== 10'd0) begin tests_failed++; $display("FAIL fault_reset got fault=%b pc=%0d want 0/0", FAULT, INSTR_ADDR); end
  endtask

  task automatic test_upper_bound();
    clear_program();
    start_at(10'd1022);
    tick();
    tests_run++;
    if (INSTR_ADDR !== 10'd1023 || FAULT !== 1'b0 || INSTR_VALID !== 1'b1) begin
      tests_failed++; $display("FAIL upper_last got pc=%0d fault=%b valid=%b want 1023/0/1", INSTR_ADDR, FAULT, INSTR_VALID);
    end
    tick();
    tests_run++;
    if (FAULT !== 1'b1 || INSTR_ADDR !== 10'd1023) begin tests_failed++; $display("FAIL upper_fault got fault=%b pc=%0d want 1/1023", FAULT, INSTR_ADDR); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    clear_program();
    start_at(10'd35);
    tick();
    tick();
    tests_run++;
    if (INSTR_ADDR !== 10'd37 || INSTR_VALID !== 1'b1) begin tests_failed++; $display("FAIL mid_setup got pc=%0d valid=%b want 37/1", INSTR_ADDR, INSTR_VALID); end
    RESET = 1'b1;
    START = 1'b1;
    START_ADDR = 10'd5;
    tick();
    RESET = 1'b0;
    START = 1'b0;
    tests_run++;
    if (INSTR_ADDR !== 10'd0 || INSTR_VALID !== 1'b0 || DONE !== 1'b0 || CYCLE_COUNT !== 16'd0) begin
      tests_failed++; $display("FAIL mid_reset got pc=%0d valid=%b done=%b count=%0d want 0/0/0/0", INSTR_ADDR, INSTR_VALID, DONE, CYCLE_COUNT);
    end
    tick();
    tests_run++;
    if (INSTR_VALID !== 1'b0 || INSTR_ADDR !== 10'd0) begin tests_failed++; $display("FAIL mid_idle got valid=%b pc=%0d want 0/0", INSTR_VALID, INSTR_ADDR); end
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    START_ADDR = '0;
    BRANCH_TAKEN = 1'b0;
    clear_program();
    tick();
    test_reset();
    test_straight_line();
    test_restart();
    test_backward_branch();
    test_not_taken();
    test_spin();
    test_range_fault();
    test_upper_bound();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
